// File: rtl/wavelet_core_ctrl_if.sv
// Control/status bundle between the wavelet core sequencer and its datapath.
// master = sequencer side, slave = datapath/config side.
interface wavelet_core_ctrl_if #(
    parameter int unsigned FS_WIDTH         = 5,
    parameter int unsigned IBUFF_ADDR_WIDTH = 11
);
    logic                        core_init;
    logic                        core_go;
    logic                        core_input_reg_en_pulse;
    logic [FS_WIDTH-1:0]         core_filter_size;
    logic                        pause_work;
    logic                        pe_job_done;
    logic                        last_dec_level;
    logic [IBUFF_ADDR_WIDTH-1:0] ibuff_w_offset;
    logic [IBUFF_ADDR_WIDTH-1:0] cur_abs_inputs_len;
    logic                        obuff_r_last_input;

    logic       clear_core_go;
    logic       clear_core_init;
    logic       pe_init;
    logic       pe_go;
    logic       fir_disable_freezing;
    logic       fir_force_freeze;
    logic       cur_dec_level_cen;
    logic       clear_cur_dec_level;
    logic       ibuff_w_en;
    logic       ibuff_w_offset_cen;
    logic       ibuff_w_offset_rst;
    logic       ibuff_w_base_reg_rst;
    logic       ibuff_w_sel_input_reg;
    logic       ibuff_w_sel_obuff_r_data;
    logic       ibuff_w_sel_erase;
    logic       obuff_r_en;
    logic       obuff_r_offset_rst;
    logic       obuff_r_offset_cen;
    logic       obuff_r_base_reg_rst;
    logic       obuff_r_service_rst;
    logic       core_busy;
    logic [2:0] ctrl_state;

    modport master (
        input  core_init, core_go, core_input_reg_en_pulse, core_filter_size, pause_work,
               pe_job_done, last_dec_level, ibuff_w_offset, cur_abs_inputs_len,
               obuff_r_last_input,
        output clear_core_go, clear_core_init, pe_init, pe_go, fir_disable_freezing,
               fir_force_freeze, cur_dec_level_cen, clear_cur_dec_level, ibuff_w_en,
               ibuff_w_offset_cen, ibuff_w_offset_rst, ibuff_w_base_reg_rst,
               ibuff_w_sel_input_reg, ibuff_w_sel_obuff_r_data, ibuff_w_sel_erase,
               obuff_r_en, obuff_r_offset_rst, obuff_r_offset_cen, obuff_r_base_reg_rst,
               obuff_r_service_rst, core_busy, ctrl_state
    );

    modport slave (
        output core_init, core_go, core_input_reg_en_pulse, core_filter_size, pause_work,
               pe_job_done, last_dec_level, ibuff_w_offset, cur_abs_inputs_len,
               obuff_r_last_input,
        input  clear_core_go, clear_core_init, pe_init, pe_go, fir_disable_freezing,
               fir_force_freeze, cur_dec_level_cen, clear_cur_dec_level, ibuff_w_en,
               ibuff_w_offset_cen, ibuff_w_offset_rst, ibuff_w_base_reg_rst,
               ibuff_w_sel_input_reg, ibuff_w_sel_obuff_r_data, ibuff_w_sel_erase,
               obuff_r_en, obuff_r_offset_rst, obuff_r_offset_cen, obuff_r_base_reg_rst,
               obuff_r_service_rst, core_busy, ctrl_state
    );
endinterface

// File: rtl/wavelet_core_ctrl.sv
// Wavelet core sequencing FSM: input load, erase padding, PE run, obuff->ibuff copy.
// Optional RUN watchdog and ERROR state: define WAVELET_CORE_CTRL_WATCHDOG_EN.
module wavelet_core_ctrl #(
    parameter int unsigned IBUFF_CELL_COUNT = 2048,
    parameter int unsigned OBUFF_CELL_COUNT = 4096,
    parameter int unsigned MAX_FILTER_SIZE  = 32,
    parameter int unsigned FS_WIDTH         = $clog2(MAX_FILTER_SIZE),
    parameter int unsigned IBUFF_ADDR_WIDTH = $clog2(IBUFF_CELL_COUNT),
    parameter int unsigned WATCHDOG_CYCLES  = 65535
) (
    input  logic              clk,
    input  logic              rst,
`ifdef WAVELET_CORE_CTRL_WATCHDOG_EN
    output logic              o_ctrl_error,
`endif
    wavelet_core_ctrl_if.master bus
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_LOAD    = 3'd1;
    localparam logic [2:0] S_ERASE   = 3'd2;
    localparam logic [2:0] S_PE_INIT = 3'd3;
    localparam logic [2:0] S_RUN     = 3'd4;
    localparam logic [2:0] S_COPY    = 3'd5;
    localparam logic [2:0] S_DONE    = 3'd6;
    localparam logic [2:0] S_ERROR   = 3'd7;

    if (OBUFF_CELL_COUNT == 0 || WATCHDOG_CYCLES == 0 || WATCHDOG_CYCLES > 65535) begin : g_bad_cfg
        $error("wavelet_core_ctrl: invalid OBUFF_CELL_COUNT or WATCHDOG_CYCLES");
    end

    logic [2:0]                  r_state;
    logic [2:0]                  w_state_d;
    logic                        r_rd_q;
    logic                        r_last_q;
    logic                        w_rd;
    logic                        w_last_d;
    logic [IBUFF_ADDR_WIDTH-1:0] w_fs_last;
    logic [IBUFF_ADDR_WIDTH-1:0] w_len_last;

    assign w_fs_last  = IBUFF_ADDR_WIDTH'(bus.core_filter_size) - 1'b1;
    assign w_len_last = bus.cur_abs_inputs_len - 1'b1;

`ifdef WAVELET_CORE_CTRL_WATCHDOG_EN
    logic [15:0] r_wd_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wd_cnt <= '0;
        end else if (r_state == S_PE_INIT) begin
            r_wd_cnt <= '0;
        end else if (r_state == S_RUN && !bus.pause_work) begin
            r_wd_cnt <= r_wd_cnt + 16'd1;
        end
    end

    assign o_ctrl_error = (r_state == S_ERROR);
`endif

    always_comb begin
        w_state_d                    = r_state;
        w_rd                         = 1'b0;
        bus.clear_core_go            = 1'b0;
        bus.clear_core_init          = 1'b0;
        bus.pe_init                  = 1'b0;
        bus.pe_go                    = 1'b0;
        bus.fir_disable_freezing     = 1'b0;
        bus.fir_force_freeze         = 1'b0;
        bus.cur_dec_level_cen        = 1'b0;
        bus.clear_cur_dec_level      = 1'b0;
        bus.ibuff_w_en               = 1'b0;
        bus.ibuff_w_offset_cen       = 1'b0;
        bus.ibuff_w_offset_rst       = 1'b0;
        bus.ibuff_w_base_reg_rst     = 1'b0;
        bus.ibuff_w_sel_input_reg    = 1'b0;
        bus.ibuff_w_sel_obuff_r_data = 1'b0;
        bus.ibuff_w_sel_erase        = 1'b0;
        bus.obuff_r_en               = 1'b0;
        bus.obuff_r_offset_rst       = 1'b0;
        bus.obuff_r_offset_cen       = 1'b0;
        bus.obuff_r_base_reg_rst     = 1'b0;
        bus.obuff_r_service_rst      = 1'b0;

        case (r_state)
            S_LOAD: begin
                bus.ibuff_w_sel_input_reg = 1'b1;
                if (bus.core_input_reg_en_pulse) begin
                    bus.ibuff_w_en         = 1'b1;
                    bus.ibuff_w_offset_cen = 1'b1;
                    if (bus.ibuff_w_offset == w_len_last) begin
                        bus.clear_core_init = 1'b1;
                        w_state_d           = S_IDLE;
                    end
                end
            end
            S_ERASE: begin
                bus.ibuff_w_sel_erase  = 1'b1;
                bus.ibuff_w_en         = 1'b1;
                bus.ibuff_w_offset_cen = 1'b1;
                if (bus.ibuff_w_offset == w_fs_last) w_state_d = S_PE_INIT;
            end
            S_PE_INIT: begin
                bus.pe_init = 1'b1;
                w_state_d   = S_RUN;
            end
            S_RUN: begin
                bus.pe_go            = 1'b1;
                bus.fir_force_freeze = bus.pause_work;
                if (bus.pe_job_done) begin
                    if (bus.last_dec_level) begin
                        w_state_d = S_DONE;
                    end else begin
                        w_state_d                = S_COPY;
                        bus.cur_dec_level_cen    = 1'b1;
                        bus.obuff_r_base_reg_rst = 1'b1;
                        bus.obuff_r_offset_rst   = 1'b1;
                        bus.ibuff_w_offset_rst   = 1'b1;
                    end
                end
`ifdef WAVELET_CORE_CTRL_WATCHDOG_EN
                else if (!bus.pause_work && r_wd_cnt == 16'(WATCHDOG_CYCLES - 1)) begin
                    w_state_d = S_ERROR;
                end
`endif
            end
            S_COPY: begin
                // Reads stop once the final one is issued; writes trail reads by one cycle.
                w_rd                         = !bus.pause_work && !r_last_q;
                bus.obuff_r_en               = w_rd;
                bus.obuff_r_offset_cen       = w_rd;
                bus.ibuff_w_en               = r_rd_q;
                bus.ibuff_w_offset_cen       = r_rd_q;
                bus.ibuff_w_sel_obuff_r_data = r_rd_q;
                if (r_last_q && r_rd_q) w_state_d = S_PE_INIT;
            end
            S_DONE: begin
                bus.clear_core_go = 1'b1;
                w_state_d         = S_IDLE;
            end
`ifdef WAVELET_CORE_CTRL_WATCHDOG_EN
            S_ERROR: begin
                if (!rst && bus.core_init) begin
                    w_state_d                = S_LOAD;
                    bus.ibuff_w_offset_rst   = 1'b1;
                    bus.ibuff_w_base_reg_rst = 1'b1;
                    bus.obuff_r_service_rst  = 1'b1;
                end
            end
`endif
            default: begin
                // Gated by rst so an asserted reset forces every strobe low at once.
                if (!rst && bus.core_init) begin
                    w_state_d                = S_LOAD;
                    bus.ibuff_w_offset_rst   = 1'b1;
                    bus.ibuff_w_base_reg_rst = 1'b1;
                    bus.obuff_r_service_rst  = 1'b1;
                end else if (!rst && bus.core_go) begin
                    w_state_d                = (bus.core_filter_size == '0) ? S_PE_INIT : S_ERASE;
                    bus.ibuff_w_offset_rst   = 1'b1;
                    bus.ibuff_w_base_reg_rst = 1'b1;
                    bus.clear_cur_dec_level  = 1'b1;
                    bus.obuff_r_service_rst  = 1'b1;
                end else begin
                    w_state_d = S_IDLE;
                end
            end
        endcase
    end

    assign w_last_d = (w_state_d == S_COPY) && (r_last_q || (w_rd && bus.obuff_r_last_input));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_rd_q   <= 1'b0;
            r_last_q <= 1'b0;
        end else begin
            r_state  <= w_state_d;
            r_rd_q   <= w_rd;
            r_last_q <= w_last_d;
        end
    end

    assign bus.core_busy  = (r_state != S_IDLE);
    assign bus.ctrl_state = r_state;

endmodule

// File: tb/tb_wavelet_core_ctrl.sv
// Self-checking bench for wavelet_core_ctrl: randomized load/transform jobs against
// a job-level model (expected strobe counts), with a small datapath offset model.
module tb_wavelet_core_ctrl;
    localparam int FSW = 5;
    localparam int IAW = 11;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    wavelet_core_ctrl_if #(.FS_WIDTH(FSW), .IBUFF_ADDR_WIDTH(IAW)) bus ();

    wavelet_core_ctrl #(
        .IBUFF_CELL_COUNT(2048),
        .OBUFF_CELL_COUNT(4096),
        .MAX_FILTER_SIZE (32),
        .WATCHDOG_CYCLES (65535)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int copy_len = 1;
    int n_levels = 1;

    // Datapath model: offset and level counters the controller steers.
    logic [IAW-1:0] ib_off;
    logic [11:0]    ob_off;
    int             lvl;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            ib_off <= '0;
            ob_off <= '0;
            lvl    <= 0;
        end else begin
            if (bus.ibuff_w_offset_rst)      ib_off <= '0;
            else if (bus.ibuff_w_offset_cen) ib_off <= ib_off + 1'b1;
            if (bus.obuff_r_offset_rst)      ob_off <= '0;
            else if (bus.obuff_r_offset_cen) ob_off <= ob_off + 1'b1;
            if (bus.clear_cur_dec_level)     lvl <= 0;
            else if (bus.cur_dec_level_cen)  lvl <= lvl + 1;
        end
    end
    assign bus.ibuff_w_offset     = ib_off;
    assign bus.obuff_r_last_input = (int'(ob_off) == copy_len - 1);
    assign bus.last_dec_level     = (lvl == n_levels - 1);

    logic [20:0] outs;
    assign outs = {bus.clear_core_go, bus.clear_core_init, bus.pe_init, bus.pe_go,
                   bus.fir_disable_freezing, bus.fir_force_freeze, bus.cur_dec_level_cen,
                   bus.clear_cur_dec_level, bus.ibuff_w_en, bus.ibuff_w_offset_cen,
                   bus.ibuff_w_offset_rst, bus.ibuff_w_base_reg_rst, bus.ibuff_w_sel_input_reg,
                   bus.ibuff_w_sel_obuff_r_data, bus.ibuff_w_sel_erase, bus.obuff_r_en,
                   bus.obuff_r_offset_rst, bus.obuff_r_offset_cen, bus.obuff_r_base_reg_rst,
                   bus.obuff_r_service_rst, bus.core_busy};

    // Event monitor: counts strobes and records protocol violations.
    int c_load = 0, c_erase = 0, c_rd = 0, c_cwr = 0, c_init = 0, c_cen = 0;
    int c_clr_init = 0, c_clr_go = 0, c_clr_lvl = 0, c_bad = 0, wr_idx = 0;
    logic prev_rd = 1'b0;
    logic [2:0] sels;
    assign sels = {bus.ibuff_w_sel_input_reg, bus.ibuff_w_sel_obuff_r_data, bus.ibuff_w_sel_erase};

    always @(negedge clk) begin
        if (rst) begin
            prev_rd <= 1'b0;
            wr_idx  <= 0;
        end else begin
            c_load     <= c_load + int'(bus.ibuff_w_en && bus.ibuff_w_sel_input_reg);
            c_erase    <= c_erase + int'(bus.ibuff_w_en && bus.ibuff_w_sel_erase);
            c_rd       <= c_rd + int'(bus.obuff_r_en);
            c_cwr      <= c_cwr + int'(bus.ibuff_w_en && bus.ibuff_w_sel_obuff_r_data);
            c_init     <= c_init + int'(bus.pe_init);
            c_cen      <= c_cen + int'(bus.cur_dec_level_cen);
            c_clr_init <= c_clr_init + int'(bus.clear_core_init);
            c_clr_go   <= c_clr_go + int'(bus.clear_core_go);
            c_clr_lvl  <= c_clr_lvl + int'(bus.clear_cur_dec_level);
            c_bad <= c_bad
                + int'(bus.ibuff_w_en && int'(bus.ibuff_w_offset) != wr_idx)
                + int'($countones(sels) > 1 || (bus.ibuff_w_en && sels == 3'b000))
                + int'(prev_rd != (bus.ibuff_w_en && bus.ibuff_w_sel_obuff_r_data))
                + int'(bus.obuff_r_en && bus.pause_work)
                + int'(bus.obuff_r_offset_cen != bus.obuff_r_en)
                + int'(bus.ibuff_w_offset_cen != bus.ibuff_w_en)
                + int'(bus.fir_disable_freezing)
                + int'((bus.ctrl_state == 3'd4)
                       ? (bus.pe_go !== 1'b1 || bus.fir_force_freeze !== bus.pause_work)
                       : (bus.pe_go || bus.fir_force_freeze));
            prev_rd <= bus.obuff_r_en;
            if (bus.ibuff_w_offset_rst) wr_idx <= 0;
            else if (bus.ibuff_w_en)    wr_idx <= wr_idx + 1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_state(input logic [2:0] s, input int budget, input string what);
        int k = 0;
        while (bus.ctrl_state !== s && k < budget) begin
            tick();
            k++;
        end
        n_checks++;
        if (bus.ctrl_state !== s) begin
            n_fail++;
            $display("FAIL %s: timed out, state=%0d required %0d", what, bus.ctrl_state, s);
        end
    endtask

    task automatic test_reset();
        bus.core_init               = 1'b1;
        bus.core_go                 = 1'b1;
        bus.core_input_reg_en_pulse = 1'b0;
        bus.core_filter_size        = '0;
        bus.pause_work              = 1'b0;
        bus.pe_job_done             = 1'b0;
        bus.cur_abs_inputs_len      = '0;
        rst = 1'b1;
        tick();
        tick();
        n_checks++;
        if (outs !== '0) begin
            n_fail++;
            $display("FAIL reset_outs: got %h required 0", outs);
        end
        n_checks++;
        if (bus.ctrl_state !== 3'd0) begin
            n_fail++;
            $display("FAIL reset_state: got %0d required 0", bus.ctrl_state);
        end
        bus.core_init = 1'b0;
        bus.core_go   = 1'b0;
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_load(input int len, input int gap_max);
        int l0 = c_load, i0 = c_clr_init, b0 = c_bad;
        bus.cur_abs_inputs_len = IAW'(len);
        bus.core_init = 1'b1;
        tick();
        bus.core_init = 1'b0;
        for (int i = 0; i < len; i++) begin
            repeat ($urandom_range(gap_max, 0)) tick();
            bus.core_input_reg_en_pulse = 1'b1;
            tick();
            bus.core_input_reg_en_pulse = 1'b0;
        end
        tick();
        n_checks++;
        if (c_load - l0 !== len) begin
            n_fail++;
            $display("FAIL load_writes: got %0d required %0d", c_load - l0, len);
        end
        n_checks++;
        if (c_clr_init - i0 !== 1) begin
            n_fail++;
            $display("FAIL load_clear_init: got %0d required 1", c_clr_init - i0);
        end
        n_checks++;
        if (bus.ctrl_state !== 3'd0 || bus.core_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL load_idle: state=%0d busy=%b required 0/0", bus.ctrl_state, bus.core_busy);
        end
        n_checks++;
        if (c_bad - b0 !== 0) begin
            n_fail++;
            $display("FAIL load_protocol: %0d violations required 0", c_bad - b0);
        end
    endtask

    // pmode: 0 no pause, 1 random pauses, 2 two-cycle pause early in each copy
    task automatic test_job(input int fs, input int levels, input int clen, input int pmode);
        int e0 = c_erase, r0 = c_rd, w0 = c_cwr, p0 = c_init, v0 = c_cen;
        int g0 = c_clr_go, i0 = c_clr_init, z0 = c_clr_lvl, b0 = c_bad;
        int exp_rd = (levels - 1) * clen;
        bus.core_filter_size = FSW'(fs);
        n_levels = levels;
        copy_len = clen;
        bus.core_go = 1'b1;
        tick();
        bus.core_go = 1'b0;
        for (int lv = 0; lv < levels; lv++) begin
            wait_state(3'd4, fs + 20, "job_reach_run");
            repeat ($urandom_range(5, 1)) begin
                bus.pause_work = (pmode != 0) && ($urandom_range(2, 0) == 0);
                tick();
            end
            bus.pause_work  = 1'b0;
            bus.pe_job_done = 1'b1;
            tick();
            bus.pe_job_done = 1'b0;
            if (lv < levels - 1) begin
                for (int k = 0; k < 200 && bus.ctrl_state !== 3'd4; k++) begin
                    bus.pause_work = (pmode == 1) ? ($urandom_range(2, 0) == 0)
                                                  : (pmode == 2 && (k == 2 || k == 3));
                    tick();
                end
                bus.pause_work = 1'b0;
            end
        end
        wait_state(3'd0, 10, "job_back_to_idle");
        n_checks++;
        if (c_erase - e0 !== fs) begin
            n_fail++;
            $display("FAIL job_erase: got %0d required %0d", c_erase - e0, fs);
        end
        n_checks++;
        if (c_init - p0 !== levels) begin
            n_fail++;
            $display("FAIL job_pe_init: got %0d required %0d", c_init - p0, levels);
        end
        n_checks++;
        if (c_cen - v0 !== levels - 1) begin
            n_fail++;
            $display("FAIL job_level_cen: got %0d required %0d", c_cen - v0, levels - 1);
        end
        n_checks++;
        if (c_rd - r0 !== exp_rd || c_cwr - w0 !== exp_rd) begin
            n_fail++;
            $display("FAIL job_copy: reads=%0d writes=%0d required %0d each",
                     c_rd - r0, c_cwr - w0, exp_rd);
        end
        n_checks++;
        if (c_clr_go - g0 !== 1 || c_clr_init - i0 !== 0 || c_clr_lvl - z0 !== 1) begin
            n_fail++;
            $display("FAIL job_clears: go=%0d init=%0d lvl=%0d required 1/0/1",
                     c_clr_go - g0, c_clr_init - i0, c_clr_lvl - z0);
        end
        n_checks++;
        if (c_bad - b0 !== 0) begin
            n_fail++;
            $display("FAIL job_protocol: %0d violations required 0", c_bad - b0);
        end
    endtask

    task automatic test_reset_mid(input bit in_copy);
        int g0, i0;
        bus.core_filter_size = FSW'(2);
        n_levels = 2;
        copy_len = 6;
        bus.core_go = 1'b1;
        tick();
        bus.core_go = 1'b0;
        wait_state(3'd4, 30, "rst_reach_run");
        if (in_copy) begin
            bus.pe_job_done = 1'b1;
            tick();
            bus.pe_job_done = 1'b0;
            tick();
            tick();
        end
        g0 = c_clr_go;
        i0 = c_clr_init;
        bus.core_go = 1'b1;
        rst = 1'b1;
        #1;
        n_checks++;
        if (outs !== '0 || bus.ctrl_state !== 3'd0) begin
            n_fail++;
            $display("FAIL reset_mid_%0d: outs=%h state=%0d required 0/0", in_copy, outs,
                     bus.ctrl_state);
        end
        bus.core_go = 1'b0;
        tick();
        rst = 1'b0;
        tick();
        tick();
        n_checks++;
        if (c_clr_go !== g0 || c_clr_init !== i0 || bus.ctrl_state !== 3'd0) begin
            n_fail++;
            $display("FAIL reset_mid_clears_%0d: go=%0d init=%0d state=%0d required 0/0/0",
                     in_copy, c_clr_go - g0, c_clr_init - i0, bus.ctrl_state);
        end
    endtask

    task automatic test_back_to_back();
        test_load($urandom_range(12, 1), 0);
        test_job($urandom_range(6, 0), $urandom_range(3, 1), $urandom_range(6, 1), 1);
        test_load($urandom_range(12, 1), 2);
    endtask

    initial begin
        test_reset();
        test_load(8, 0);
        test_load(8, 2);
        for (int i = 0; i < 3; i++) test_load($urandom_range(16, 1), 3);
        test_job(4, 1, 1, 0);
        test_job(3, 3, 5, 0);
        test_job(0, 2, 3, 0);
        test_job(2, 2, 5, 2);
        test_job(31, 2, 1, 0);
        for (int i = 0; i < 5; i++)
            test_job($urandom_range(8, 0), $urandom_range(4, 1), $urandom_range(7, 1), 1);
        test_reset_mid(1'b0);
        test_reset_mid(1'b1);
        test_job(4, 2, 4, 1);
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
